// File: rtl/btn_event.sv
// Per-button event decoder: turns debounced levels into press/release/long pulses.
// Define BTN_REPEAT_EN to enable auto-repeat press pulses while a button is held.
module btn_event_lane #(
  parameter logic [7:0] LONG_TICKS   = 8'd100,
  parameter logic [7:0] REPEAT_TICKS = 8'd20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cur,
  input  logic prv,
  input  logic tick,
  output logic ev_press,
  output logic ev_rel,
  output logic ev_long
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] PRESSED = 2'd1;
  localparam logic [1:0] HELD    = 2'd2;

  logic [1:0] state;
  logic [7:0] hold_cnt;
  logic [7:0] hold_nxt;

  assign hold_nxt = hold_cnt + 8'd1;

`ifdef BTN_REPEAT_EN
  logic [7:0] rep_cnt;
  logic [7:0] rep_nxt;
  assign rep_nxt = rep_cnt + 8'd1;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      hold_cnt <= 8'd0;
      ev_press <= 1'b0;
      ev_rel   <= 1'b0;
      ev_long  <= 1'b0;
`ifdef BTN_REPEAT_EN
      rep_cnt  <= 8'd0;
`endif
    end else begin
      ev_press <= 1'b0;
      ev_rel   <= 1'b0;
      ev_long  <= 1'b0;
      case (state)
        IDLE: if (cur && !prv) begin
          ev_press <= 1'b1;
          hold_cnt <= 8'd0;
          state    <= PRESSED;
        end
        PRESSED: begin
          // release wins over a coincident tick
          if (!cur) begin
            ev_rel <= 1'b1;
            state  <= IDLE;
          end else if (tick) begin
            hold_cnt <= hold_nxt;
            if (hold_nxt == LONG_TICKS) begin
              ev_long <= 1'b1;
              state   <= HELD;
`ifdef BTN_REPEAT_EN
              rep_cnt <= 8'd0;
`endif
            end
          end
        end
        HELD: begin
          if (!cur) begin
            ev_rel <= 1'b1;
            state  <= IDLE;
          end else if (tick) begin
            if (hold_cnt != 8'hFF) hold_cnt <= hold_nxt;
`ifdef BTN_REPEAT_EN
            if (rep_nxt == REPEAT_TICKS) begin
              ev_press <= 1'b1;
              rep_cnt  <= 8'd0;
            end else begin
              rep_cnt  <= rep_nxt;
            end
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

module btn_event #(
  parameter int         BTN_WIDTH    = 8,
  parameter logic       BTN_ACTIVE   = 1'b0,
  parameter int         TICK_W       = 18,
  parameter logic [7:0] LONG_TICKS   = 8'd100,
  parameter logic [7:0] REPEAT_TICKS = 8'd20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [BTN_WIDTH-1:0] btn_deb,
  output logic [BTN_WIDTH-1:0] btn_level,
  output logic [BTN_WIDTH-1:0] btn_press,
  output logic [BTN_WIDTH-1:0] btn_release,
  output logic [BTN_WIDTH-1:0] btn_long
);
  logic [BTN_WIDTH-1:0] cur;
  logic [BTN_WIDTH-1:0] prv;
  logic [TICK_W-1:0]    presc;
  logic                 tick;

  assign tick      = &presc;
  assign btn_level = cur;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur   <= '0;
      prv   <= '0;
      presc <= '0;
    end else begin
      // normalise polarity so cur is 1 = pressed
      cur   <= ~(btn_deb ^ {BTN_WIDTH{BTN_ACTIVE}});
      prv   <= cur;
      presc <= presc + TICK_W'(1);
    end
  end

  for (genvar i = 0; i < BTN_WIDTH; i++) begin : g_lane
    btn_event_lane #(
      .LONG_TICKS  (LONG_TICKS),
      .REPEAT_TICKS(REPEAT_TICKS)
    ) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .cur     (cur[i]),
      .prv     (prv[i]),
      .tick    (tick),
      .ev_press(btn_press[i]),
      .ev_rel  (btn_release[i]),
      .ev_long (btn_long[i])
    );
  end
endmodule
